// File: rtl/syn_down.sv
// syn_down: fully synchronous loadable down-counter with a one-cycle
// terminal-count pulse and optional auto-reload. The FSM state is fully
// visible on the outputs: busy marks RUN, done marks DONE, and neither
// being set means IDLE.
module syn_down #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] reload_r;
    logic [WIDTH-1:0] reload_d;
    logic             tc_r;
    logic             tc_d;

    // Register stage: reset wins over everything, otherwise take next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            q_r      <= '0;
            reload_r <= '0;
            tc_r     <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_r      <= q_d;
            reload_r <= reload_d;
            tc_r     <= tc_d;
        end
    end

    // Next-state logic: load beats counting; tc only on the terminal step.
    always_comb begin
        state_d  = state_q;
        q_d      = q_r;
        reload_d = reload_r;
        tc_d     = 1'b0;
        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            state_d  = (load_val != '0) ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    // RUN is only ever entered with a non-zero count, and a
                    // reload value that is itself non-zero, so q >= 1 here.
                    if (en) begin
                        if (q_r == WIDTH'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                q_d = reload_r;
                            end else begin
                                q_d     = '0;
                                state_d = S_DONE;
                            end
                        end else begin
                            q_d = q_r - WIDTH'(1);
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    q_d = q_r;
                end
                default: begin
                    state_d = S_IDLE;
                    q_d     = '0;
                end
            endcase
        end
    end

    assign q    = q_r;
    assign tc   = tc_r;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign zero = (q_r == '0);

endmodule

// File: tb/tb_syn_down.sv
// Directed testbench for syn_down (WIDTH=4). Inputs change 1 time unit after
// a rising edge; outputs are checked at that same point, after the edge has
// settled.
module tb_syn_down;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;
    logic         zero;

    int checks = 0;
    int errors = 0;

    syn_down #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .load_val    (load_val),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy),
        .done        (done),
        .zero        (zero)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check all registered/derived outputs at once.
    task automatic chk_all(input string tag, input logic [W-1:0] eq, input logic etc,
                           input logic ebusy, input logic edone);
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".tc"}, 32'(tc), 32'(etc));
        chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
        chk({tag, ".done"}, 32'(done), 32'(edone));
        chk({tag, ".zero"}, 32'(zero), 32'(eq == '0));
    endtask

    logic [W-1:0] ar_q  [6] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    logic         ar_tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic         eg_en [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] eg_q  [5] = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1};

    initial begin
        int n;
        rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;
        tick();

        // Reset after random activity.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            load        = 1'($urandom_range(0, 1));
            load_val    = W'($urandom_range(0, 15));
            en          = 1'($urandom_range(0, 1));
            auto_reload = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b1; load = 1'b0;
        tick();
        tick();
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        // Reset together with load: reset wins.
        load = 1'b1; load_val = 4'd7; en = 1'b1;
        tick();
        chk_all("reset_vs_load", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; load = 1'b0; en = 1'b0; auto_reload = 1'b0;
        tick();
        chk_all("idle_en_ignored", 4'd0, 1'b0, 1'b0, 1'b0);

        // One-shot from 5.
        load = 1'b1; load_val = 4'd5; en = 1'b1; auto_reload = 1'b0;
        tick();
        chk_all("os_load", 4'd5, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk_all("os_count", W'(i), (i == 0), (i != 0), (i == 0));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("os_hold", 4'd0, 1'b0, 1'b0, 1'b1);
        end

        // Auto-reload from 3.
        load = 1'b1; load_val = 4'd3; auto_reload = 1'b1;
        tick();
        chk_all("ar_load", 4'd3, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_all("ar_count", ar_q[i], ar_tc[i], 1'b1, 1'b0);
        end

        // Enable gating.
        load = 1'b1; load_val = 4'd4; en = 1'b0; auto_reload = 1'b0;
        tick();
        chk_all("eg_load", 4'd4, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en = eg_en[i];
            tick();
            chk_all("eg_count", eg_q[i], 1'b0, 1'b1, 1'b0);
        end

        // Reload mid-count, then load of 0.
        load = 1'b1; load_val = 4'd3; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk_all("mid_at2", 4'd2, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_val = 4'd9;
        tick();
        chk_all("mid_load9", 4'd9, 1'b0, 1'b1, 1'b0);
        load_val = 4'd0;
        tick();
        chk_all("load0", 4'd0, 1'b0, 1'b0, 1'b0);

        // Load on the terminal step suppresses tc.
        load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0;
        tick();
        chk_all("term_at1", 4'd1, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_val = 4'd6;
        tick();
        chk_all("term_load", 4'd6, 1'b0, 1'b1, 1'b0);
        load = 1'b0;

        // Reset on the terminal step: no tc.
        load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_all("rst_term", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Full width: 15 enabled edges to tc.
        load = 1'b1; load_val = 4'd15; en = 1'b1; auto_reload = 1'b0;
        tick();
        chk_all("fw_load", 4'd15, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (tc) break;
        end
        chk("fw_edges", 32'(n), 32'd15);
        chk_all("fw_end", 4'd0, 1'b1, 1'b0, 1'b1);

        // Reload value 1 with auto-reload: tc every enabled cycle.
        load = 1'b1; load_val = 4'd1; auto_reload = 1'b1;
        tick();
        chk_all("r1_load", 4'd1, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all("r1_tc", 4'd1, 1'b1, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/syn_down.md
# syn_down

Synchronous, loadable down-counter with terminal-count pulse and optional auto-reload. It is the count-down companion to the team's ripple up-counter, but it is fully synchronous: every flop is clocked by `clk`, and no flop output is used as a clock. It serves as the programmable interval and timeout source for the counter library and downstream control logic.

## Interface
Parameters:
- `WIDTH`, default 4: width of the counter and of the load value.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `load`, input, 1: load `load_val` into the counter and into the reload register.
- `load_val`, input, WIDTH: start value and reload value.
- `en`, input, 1: count enable; honoured only in RUN.
- `auto_reload`, input, 1: reload on terminal count instead of stopping; sampled at the terminal edge.
- `q`, output, WIDTH: current count, registered.
- `tc`, output, 1: terminal-count pulse, registered, high for exactly one cycle.
- `busy`, output, 1: high when state is RUN.
- `done`, output, 1: high when state is DONE.
- `zero`, output, 1: combinational `q == 0`.

## Operation
- Internal state is three-state: IDLE, RUN, DONE. There is also a `reload` register of WIDTH bits.
- Reset (`rst`=1 at an edge; overrides every other input):
  - state=IDLE, q=0, reload=0, tc=0.
  - Resulting outputs: busy=0, done=0, zero=1.
- Priority at each edge is: `rst` > `load` > count.
- `load`=1 (accepted in any state):
  - q<=load_val and reload<=load_val.
  - Next state is RUN if load_val≠0, otherwise IDLE.
  - tc<=0, even if the counter was at its terminal step in that cycle.
- RUN, `en`=0: q holds, tc<=0.
- RUN, `en`=1, q>1: q<=q−1, tc<=0.
- RUN, `en`=1, q==1 (the terminal step), tc<=1 in both cases:
  - `auto_reload`=1: q<=reload, state stays RUN.
  - `auto_reload`=0: q<=0, state<=DONE.
- IDLE and DONE: `en` is ignored, q holds (0), tc<=0. Only `load` leaves these states.
- Arithmetic: unsigned, modulo 2^WIDTH. q never underflows, because decrement from 0 cannot occur in RUN (RUN implies q≥1).
- reload=1 with `auto_reload`=1: q stays 1, and tc is high on every enabled cycle.
- `auto_reload` changes mid-count: only its value at the terminal edge matters.

## Timing
- Load latency: `load` sampled at edge N gives q=load_val after edge N and busy=1 from edge N.
- Count latency: with `en` held high after a load of L (L≥1), q reaches 0 (or reloads) at the L-th enabled edge after the load edge.
  - tc is high for the cycle following that edge.
  - done rises at the same edge (non-reload case).
- tc is never high for two consecutive cycles except in the reload=1 auto-reload case.
- Reset mid-count: at the next edge all registers return to reset values. No tc is emitted.
- All outputs except `zero` are registered. `zero` is derived only from `q`.

## Test plan
- Reset: drive random inputs, then assert `rst` for 2 cycles. Required: q=0, tc=0, busy=0, done=0, zero=1. Repeat with `rst`=1 and `load`=1 together; `rst` must win.
- One-shot, WIDTH=4: load 5, `en`=1, `auto_reload`=0. Required: q=5,4,3,2,1,0; tc high for exactly one cycle, coincident with q=0; done=1 and busy=0 from that edge; q stays 0 for 10 more enabled cycles with no further tc.
- Auto-reload: load 3, `en`=1, `auto_reload`=1. Required: q=3,2,1,3,2,1,3; tc pulses in each cycle where q has just reloaded to 3; busy stays 1.
- Enable gating: load 4, then drive `en`=1,0,0,1,1. Required: q=4,3,3,3,2,1; tc=0 throughout.
- Reload mid-count and load of 0:
  - At q=2, assert load with 9. Required: q=9 next cycle, no tc.
  - Then load 0. Required: state IDLE, q=0, busy=0, done=0, tc=0.
- Full width: load 15, `en`=1. Required: tc after exactly 15 enabled edges. Also load 1 with `auto_reload`=1: tc high on every cycle, q=1 constant.
